// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO: registered full/empty flags, head word read
// combinationally from the storage array.
module fifo_sync #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic                  shift_in,
   input  logic                  shift_out,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  push_c;
   logic                  pop_c;

   // Accept conditions; a pop frees a slot so a full FIFO can take a push in the same cycle
   always_comb begin
      pop_c  = shift_out && !empty_q;
      push_c = shift_in && (!full_q || shift_out);
   end

   // Next-state for storage, pointers, occupancy and flags
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      if (push_c) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      if (push_c && !pop_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      full_d  = (cnt_d == CNT_W'(DEPTH));
      empty_d = (cnt_d == CNT_W'(0));
   end

   // State registers with synchronous active-high reset that clears storage too
   always_ff @(posedge clk) begin
      if (res_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Show-ahead head word; stale while empty
   always_comb begin
      full     = full_q;
      empty    = empty_q;
      data_out = mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync.
`timescale 1ns/1ps
module tb_fifo_sync;

   localparam int unsigned DW = 64;

   logic          clk;
   logic          res_n;
   logic          shift_in;
   logic          shift_out;
   logic [DW-1:0] data_in;
   logic          full;
   logic          empty;
   logic [DW-1:0] data_out;

   int checks = 0;
   int errors = 0;

   fifo_sync #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
      .clk       (clk),
      .res_n     (res_n),
      .shift_in  (shift_in),
      .shift_out (shift_out),
      .data_in   (data_in),
      .full      (full),
      .empty     (empty),
      .data_out  (data_out)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench
   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] exp_wrap [8];

   initial begin
      res_n     = 1'b1;
      shift_in  = 1'b0;
      shift_out = 1'b0;
      data_in   = '0;

      // Reset
      tick();
      tick();
      res_n = 1'b0;
      check("rst_empty", DW'(empty), DW'(1));
      check("rst_full", DW'(full), DW'(0));
      check("rst_dout", data_out, DW'(0));

      // Fill with 2..9
      for (int i = 0; i < 8; i++) begin
         shift_in = 1'b1;
         data_in  = DW'(2 + i);
         tick();
         check($sformatf("fill_empty%0d", i), DW'(empty), DW'(0));
         check($sformatf("fill_full%0d", i), DW'(full), DW'(i == 7));
         check($sformatf("fill_dout%0d", i), data_out, DW'(2));
      end

      // Overflow: dropped push while full
      data_in = 64'hDEAD;
      tick();
      shift_in = 1'b0;
      check("ovf_full", DW'(full), DW'(1));
      check("ovf_dout", data_out, DW'(2));

      // Drain 2..9, then an extra pop on empty
      shift_out = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_dout%0d", i), data_out, DW'(2 + i));
         tick();
         check($sformatf("drain_full%0d", i), DW'(full), DW'(0));
      end
      check("drain_empty", DW'(empty), DW'(1));
      tick();
      shift_out = 1'b0;
      check("xpop_empty", DW'(empty), DW'(1));
      check("xpop_full", DW'(full), DW'(0));

      // Wrap: push 10..14, pop 3, push 20..25
      shift_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = DW'(10 + i);
         tick();
      end
      shift_in  = 1'b0;
      shift_out = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      shift_out = 1'b0;
      check("wrap_head", data_out, DW'(13));
      shift_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_in = DW'(20 + i);
         tick();
      end
      check("wrap_full", DW'(full), DW'(1));

      // Push+pop while full: head advances, stays full
      shift_out = 1'b1;
      data_in   = DW'(30);
      tick();
      shift_in = 1'b0;
      check("pp_full", DW'(full), DW'(1));
      check("pp_head", data_out, DW'(14));

      exp_wrap[0] = DW'(14);
      exp_wrap[1] = DW'(20);
      exp_wrap[2] = DW'(21);
      exp_wrap[3] = DW'(22);
      exp_wrap[4] = DW'(23);
      exp_wrap[5] = DW'(24);
      exp_wrap[6] = DW'(25);
      exp_wrap[7] = DW'(30);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("wdrain_dout%0d", i), data_out, exp_wrap[i]);
         tick();
      end
      shift_out = 1'b0;
      check("wdrain_empty", DW'(empty), DW'(1));

      // Push+pop while empty: only the push is taken
      shift_in  = 1'b1;
      shift_out = 1'b1;
      data_in   = DW'(40);
      tick();
      shift_out = 1'b0;
      check("ppe_empty", DW'(empty), DW'(0));
      check("ppe_dout", data_out, DW'(40));

      // Three more pushes -> 4 stored, then reset with a push pending
      for (int i = 0; i < 3; i++) begin
         data_in = DW'(41 + i);
         tick();
      end
      check("pre_rst_head", data_out, DW'(40));
      res_n   = 1'b1;
      data_in = DW'(99);
      tick();
      res_n    = 1'b0;
      shift_in = 1'b0;
      check("mrst_empty", DW'(empty), DW'(1));
      check("mrst_full", DW'(full), DW'(0));
      check("mrst_dout", data_out, DW'(0));

      // Post-reset push reads back
      shift_in = 1'b1;
      data_in  = 64'h1;
      tick();
      shift_in = 1'b0;
      check("post_empty", DW'(empty), DW'(0));
      check("post_dout", data_out, 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
